vec_mul_core: RTL and testbench

- Weight-stationary 8x8 int8 vector-matrix multiplier with its own storage.
- Holds an activation SRAM, a weight FIFO, an 8x8 weight register array, one MAC stage and a result SRAM.
- Each activation word (8 signed bytes) read from SRAM under valid_address is multiplied by the loaded weight matrix; the 8 partial sums are written to the result SRAM.
- end_ flags completion so the host can read results back through a dedicated address port.

---
 rtl/vec_mul_core.sv | 175 +++++++++++++++++
 tb/tb_vec_mul_core.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_mul_core.sv
// Weight-stationary 8x8 int8 vector-matrix multiplier with activation SRAM, weight FIFO and result SRAM.
// Define RESULT_RELU_EN to clamp negative column sums to zero before they are stored.
module vec_mul_core #(
  parameter int ADDRESSSIZE    = 10,
  parameter int WORDSIZE       = 64,
  parameter int WEIGHT_BW      = 8,
  parameter int NUM_PE_ROWS    = 8,
  parameter int MATRIX_SIZE    = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int PARTIAL_SUM_BW = 20
) (
  input  logic                                        clk,
  input  logic                                        rstn,
  input  logic                                        start,
  output logic                                        end_,
  input  logic                                        sram_write_enable,
  input  logic [ADDRESSSIZE-1:0]                      sram_address,
  input  logic [WORDSIZE-1:0]                         sram_data_in,
  output logic [WORDSIZE-1:0]                         sram_data_out,
  input  logic                                        fifo_write_enable,
  input  logic                                        fifo_read_enable,
  input  logic [WEIGHT_BW*NUM_PE_ROWS*MATRIX_SIZE-1:0] fifo_data_in,
  output logic [WEIGHT_BW*NUM_PE_ROWS*MATRIX_SIZE-1:0] fifo_data_out,
  output logic                                        fifo_empty,
  output logic                                        fifo_full,
  input  logic                                        weight_reload,
  input  logic                                        valid_address,
  input  logic                                        addr_ctrl_en,
  input  logic [ADDRESSSIZE-1:0]                      sram_result_address,
  output logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0]       sram_result_data_out
);

  localparam int MAT_W    = WEIGHT_BW * NUM_PE_ROWS * MATRIX_SIZE;
  localparam int RESULT_W = PARTIAL_SUM_BW * MATRIX_SIZE;
  localparam int PROD_W   = 2 * WEIGHT_BW;
  localparam int PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  // ---------------- Activation SRAM ----------------
  logic [WORDSIZE-1:0] act_mem [2**ADDRESSSIZE];

  // NOTE: storage arrays are written without reset; clearing them would turn RAM into flops.
  always_ff @(posedge clk) begin
    if (sram_write_enable) act_mem[sram_address] <= sram_data_in;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sram_data_out <= '0;
    else       sram_data_out <= act_mem[sram_address];
  end

  // ---------------- Weight FIFO ----------------
  logic [MAT_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] fifo_count;
  logic             push, pop;

  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign push       = fifo_write_enable && !fifo_full;
  assign pop        = fifo_read_enable && !fifo_empty;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= fifo_data_in;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_count    <= '0;
      fifo_data_out <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop) begin
        rd_ptr        <= next_ptr(rd_ptr);
        fifo_data_out <= fifo_mem[rd_ptr];
      end
      if (push && !pop)      fifo_count <= fifo_count + 1'b1;
      else if (pop && !push) fifo_count <= fifo_count - 1'b1;
    end
  end

  // ---------------- Weight array ----------------
  logic [MAT_W-1:0] weights;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)              weights <= '0;
    else if (weight_reload) weights <= fifo_data_out;
  end

  // ---------------- MAC stage ----------------
  logic signed [WEIGHT_BW-1:0]      x_e, w_e;
  logic signed [PROD_W-1:0]         prod;
  logic signed [PARTIAL_SUM_BW-1:0] acc;
  logic [RESULT_W-1:0]              result_word;

  // NOTE: blocking assignments here because acc is a running temporary; every variable gets a default first so no latch is inferred.
  always_comb begin
    x_e         = '0;
    w_e         = '0;
    prod        = '0;
    acc         = '0;
    result_word = '0;
    for (int c = 0; c < MATRIX_SIZE; c++) begin
      acc = '0;
      for (int r = 0; r < NUM_PE_ROWS; r++) begin
        x_e  = sram_data_out[r*WEIGHT_BW +: WEIGHT_BW];
        w_e  = weights[(r*MATRIX_SIZE + c)*WEIGHT_BW +: WEIGHT_BW];
        prod = x_e * w_e;
        acc  = acc + {{(PARTIAL_SUM_BW-PROD_W){prod[PROD_W-1]}}, prod};
      end
`ifdef RESULT_RELU_EN
      if (acc[PARTIAL_SUM_BW-1]) acc = '0;
`endif
      result_word[c*PARTIAL_SUM_BW +: PARTIAL_SUM_BW] = acc;
    end
  end

  // ---------------- Control FSM ----------------
  state_t                 state, next_state;
  logic                   seen_valid, drain_cnt, compute_valid;
  logic [ADDRESSSIZE-1:0] res_wptr;

  always_comb begin
    next_state = state;
    end_       = 1'b0;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (!valid_address && seen_valid) next_state = DRAIN;
      DRAIN:   if (drain_cnt) next_state = DONE;
      DONE: begin
        end_ = 1'b1;
        if (!start) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      seen_valid    <= 1'b0;
      drain_cnt     <= 1'b0;
      compute_valid <= 1'b0;
      res_wptr      <= '0;
    end else begin
      state         <= next_state;
      compute_valid <= (state == RUN) && valid_address;
      seen_valid    <= (state == RUN) && (valid_address || seen_valid);
      drain_cnt     <= (state == DRAIN) && !drain_cnt;
      if (state == IDLE && start) res_wptr <= '0;
      else if (compute_valid)     res_wptr <= res_wptr + 1'b1;
    end
  end

  // ---------------- Result SRAM ----------------
  logic [RESULT_W-1:0] res_mem [2**ADDRESSSIZE];

  always_ff @(posedge clk) begin
    if (compute_valid) res_mem[res_wptr] <= result_word;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sram_result_data_out <= '0;
    else       sram_result_data_out <= addr_ctrl_en ? res_mem[sram_result_address] : '0;
  end

endmodule

// File: tb/tb_vec_mul_core.sv
// Directed self-checking bench for vec_mul_core: reset, FIFO, identity, signed extremes, full run, readout.
module tb_vec_mul_core;

  logic         clk = 1'b0;
  logic         rstn;
  logic         start;
  logic         end_;
  logic         sram_write_enable;
  logic [9:0]   sram_address;
  logic [63:0]  sram_data_in;
  logic [63:0]  sram_data_out;
  logic         fifo_write_enable;
  logic         fifo_read_enable;
  logic [511:0] fifo_data_in;
  logic [511:0] fifo_data_out;
  logic         fifo_empty;
  logic         fifo_full;
  logic         weight_reload;
  logic         valid_address;
  logic         addr_ctrl_en;
  logic [9:0]   sram_result_address;
  logic [159:0] sram_result_data_out;

  int checks = 0;
  int errors = 0;
  logic [159:0] exp_full [8];

  vec_mul_core dut (
    .clk                  (clk),
    .rstn                 (rstn),
    .start                (start),
    .end_                 (end_),
    .sram_write_enable    (sram_write_enable),
    .sram_address         (sram_address),
    .sram_data_in         (sram_data_in),
    .sram_data_out        (sram_data_out),
    .fifo_write_enable    (fifo_write_enable),
    .fifo_read_enable     (fifo_read_enable),
    .fifo_data_in         (fifo_data_in),
    .fifo_data_out        (fifo_data_out),
    .fifo_empty           (fifo_empty),
    .fifo_full            (fifo_full),
    .weight_reload        (weight_reload),
    .valid_address        (valid_address),
    .addr_ctrl_en         (addr_ctrl_en),
    .sram_result_address  (sram_result_address),
    .sram_result_data_out (sram_result_data_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] fill_mat(input int k);
    logic [511:0] m;
    for (int b = 0; b < 64; b++) m[b*8 +: 8] = 8'(k*37 + b*3 + 1);
    return m;
  endfunction

  function automatic logic [511:0] identity_mat();
    logic [511:0] m = '0;
    for (int r = 0; r < 8; r++) m[(r*8 + r)*8 +: 8] = 8'd1;
    return m;
  endfunction

  function automatic logic [511:0] run_weights();
    logic [511:0] m;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) m[(r*8 + c)*8 +: 8] = 8'((r - c)*7 + 1);
    return m;
  endfunction

  function automatic logic [63:0] run_vec(input int k);
    logic [63:0] v;
    for (int r = 0; r < 8; r++) v[r*8 +: 8] = 8'(k*3 + r*5 - 10);
    return v;
  endfunction

  function automatic logic [159:0] golden(input int k);
    logic [159:0] g;
    int s;
    for (int c = 0; c < 8; c++) begin
      s = 0;
      for (int r = 0; r < 8; r++) s += (k*3 + r*5 - 10) * ((r - c)*7 + 1);
`ifdef RESULT_RELU_EN
      if (s < 0) s = 0;
`endif
      g[c*20 +: 20] = 20'(s);
    end
    return g;
  endfunction

  task automatic write_vec(input logic [9:0] a, input logic [63:0] d);
    sram_write_enable = 1'b1;
    sram_address      = a;
    sram_data_in      = d;
    tick();
    sram_write_enable = 1'b0;
  endtask

  task automatic load_weights(input logic [511:0] m);
    fifo_write_enable = 1'b1;
    fifo_data_in      = m;
    tick();
    fifo_write_enable = 1'b0;
    fifo_read_enable  = 1'b1;
    tick();
    fifo_read_enable  = 1'b0;
    weight_reload     = 1'b1;
    tick();
    weight_reload     = 1'b0;
  endtask

  task automatic read_result(input logic [9:0] k, output logic [159:0] d);
    addr_ctrl_en        = 1'b1;
    sram_result_address = k;
    tick();
    d = sram_result_data_out;
  endtask

  // Runs n back-to-back vectors from base and checks the end_ handshake timing.
  task automatic do_run(input logic [9:0] base, input int n);
    start = 1'b1;
    tick();
    for (int i = 0; i < n; i++) begin
      valid_address = 1'b1;
      sram_address  = base + 10'(i);
      tick();
    end
    valid_address = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      tick();
      checks++;
      if (end_ !== (j == 3)) begin
        errors++;
        $display("FAIL end_timing cycle %0d: got %b expected %b", j, end_, (j == 3));
      end
    end
    tick();
    checks++;
    if (end_ !== 1'b1) begin errors++; $display("FAIL end_hold: got %b expected 1", end_); end
    start = 1'b0;
    tick();
    checks++;
    if (end_ !== 1'b0) begin errors++; $display("FAIL end_drop: got %b expected 0", end_); end
  endtask

  task automatic test_reset();
    rstn = 1'b1;
    start = 0; sram_write_enable = 0; sram_address = '0; sram_data_in = '0;
    fifo_write_enable = 0; fifo_read_enable = 0; fifo_data_in = '0; weight_reload = 0;
    valid_address = 0; addr_ctrl_en = 0; sram_result_address = '0;
    #2 rstn = 1'b0;
    #2;
    checks += 6;
    if (end_ !== 1'b0)                 begin errors++; $display("FAIL rst_end: got %b expected 0", end_); end
    if (sram_data_out !== '0)          begin errors++; $display("FAIL rst_sram_out: got %h expected 0", sram_data_out); end
    if (fifo_data_out !== '0)          begin errors++; $display("FAIL rst_fifo_out: got %h expected 0", fifo_data_out); end
    if (fifo_empty !== 1'b1)           begin errors++; $display("FAIL rst_empty: got %b expected 1", fifo_empty); end
    if (fifo_full !== 1'b0)            begin errors++; $display("FAIL rst_full: got %b expected 0", fifo_full); end
    if (sram_result_data_out !== '0)   begin errors++; $display("FAIL rst_result_out: got %h expected 0", sram_result_data_out); end
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;
    tick();
  endtask

  task automatic test_fifo();
    for (int k = 0; k < 4; k++) begin
      fifo_write_enable = 1'b1;
      fifo_data_in      = fill_mat(k);
      tick();
    end
    checks += 2;
    if (fifo_full !== 1'b1)  begin errors++; $display("FAIL fifo_full_after4: got %b expected 1", fifo_full); end
    if (fifo_empty !== 1'b0) begin errors++; $display("FAIL fifo_empty_after4: got %b expected 0", fifo_empty); end
    fifo_data_in = fill_mat(9);
    tick();
    fifo_write_enable = 1'b0;
    checks++;
    if (fifo_full !== 1'b1) begin errors++; $display("FAIL fifo_full_after5: got %b expected 1", fifo_full); end
    for (int k = 0; k < 4; k++) begin
      fifo_read_enable = 1'b1;
      tick();
      checks++;
      if (fifo_data_out !== fill_mat(k))
        begin errors++; $display("FAIL fifo_pop%0d: got %h expected %h", k, fifo_data_out, fill_mat(k)); end
    end
    checks++;
    if (fifo_empty !== 1'b1) begin errors++; $display("FAIL fifo_empty_after_pops: got %b expected 1", fifo_empty); end
    tick();
    fifo_read_enable = 1'b0;
    checks++;
    if (fifo_data_out !== fill_mat(3))
      begin errors++; $display("FAIL fifo_pop_empty_hold: got %h expected %h", fifo_data_out, fill_mat(3)); end
    // Simultaneous push and pop on a one-entry FIFO keeps the count at one.
    fifo_write_enable = 1'b1;
    fifo_data_in      = fill_mat(5);
    tick();
    fifo_data_in      = fill_mat(6);
    fifo_read_enable  = 1'b1;
    tick();
    fifo_write_enable = 1'b0;
    checks += 2;
    if (fifo_data_out !== fill_mat(5))
      begin errors++; $display("FAIL fifo_pushpop_data: got %h expected %h", fifo_data_out, fill_mat(5)); end
    if (fifo_empty !== 1'b0) begin errors++; $display("FAIL fifo_pushpop_empty: got %b expected 0", fifo_empty); end
    tick();
    fifo_read_enable = 1'b0;
    checks += 2;
    if (fifo_data_out !== fill_mat(6))
      begin errors++; $display("FAIL fifo_pushpop_second: got %h expected %h", fifo_data_out, fill_mat(6)); end
    if (fifo_empty !== 1'b1) begin errors++; $display("FAIL fifo_final_empty: got %b expected 1", fifo_empty); end
  endtask

  task automatic test_identity();
    logic [159:0] got, want;
    write_vec(10'd0, 64'h0807060504030201);
    load_weights(identity_mat());
    do_run(10'd0, 1);
    for (int c = 0; c < 8; c++) want[c*20 +: 20] = 20'(c + 1);
    read_result(10'd0, got);
    checks++;
    if (got !== want) begin errors++; $display("FAIL identity: got %h expected %h", got, want); end
    addr_ctrl_en = 1'b0;
  endtask

  task automatic test_signed();
    logic [159:0] got, want;
    write_vec(10'd1, {8{8'h7f}});
    load_weights({64{8'h80}});
    do_run(10'd1, 1);
`ifdef RESULT_RELU_EN
    want = '0;
`else
    want = {8{20'hE0400}};
`endif
    read_result(10'd0, got);
    checks++;
    if (got !== want) begin errors++; $display("FAIL signed_extreme: got %h expected %h", got, want); end
    addr_ctrl_en = 1'b0;
  endtask

  task automatic test_full_run();
    logic [159:0] got;
    for (int k = 0; k < 8; k++) write_vec(10'(k), run_vec(k));
    load_weights(run_weights());
    for (int k = 0; k < 8; k++) exp_full[k] = golden(k);
    do_run(10'd0, 8);
    for (int k = 0; k < 8; k++) begin
      read_result(10'(k), got);
      checks++;
      if (got !== exp_full[k]) begin errors++; $display("FAIL full_run_entry%0d: got %h expected %h", k, got, exp_full[k]); end
    end
  endtask

  task automatic test_readout();
    addr_ctrl_en        = 1'b0;
    sram_result_address = 10'd3;
    tick();
    checks++;
    if (sram_result_data_out !== '0)
      begin errors++; $display("FAIL readout_disabled: got %h expected 0", sram_result_data_out); end
    addr_ctrl_en = 1'b1;
    tick();
    checks++;
    if (sram_result_data_out !== exp_full[3])
      begin errors++; $display("FAIL readout_entry3: got %h expected %h", sram_result_data_out, exp_full[3]); end
    sram_result_address = 10'd5;
    #1;
    checks++;
    if (sram_result_data_out !== exp_full[3])
      begin errors++; $display("FAIL readout_latency: got %h expected %h", sram_result_data_out, exp_full[3]); end
    tick();
    checks++;
    if (sram_result_data_out !== exp_full[5])
      begin errors++; $display("FAIL readout_entry5: got %h expected %h", sram_result_data_out, exp_full[5]); end
    addr_ctrl_en = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_fifo();
    test_identity();
    test_signed();
    test_full_run();
    test_readout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
